uart_rx_chk: RTL and testbench

UART receiver for the platform's serial path: recovers 8N1 frames from the asynchronous `rx` line using an oversampling tick and presents each byte as a single-cycle strobe. It is the receive end of the board's fixed-message UART transmitter and serves as its loopback partner. An optional checker compares the received stream against the transmitter's 13-byte message and counts mismatches.

---
 rtl/uart_rx_chk.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_chk.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_chk.sv
// uart_rx_chk -- 8N1 UART receiver with an optional fixed-message checker.
//
// Recovers bytes from the asynchronous rx line using an oversampling tick.
// Each good byte is presented on data with a one-cycle data_valid strobe.
// A low stop bit gives a one-cycle frame_err strobe, and the receiver then
// waits for the line to return high.
//
// Optional feature: define UART_RX_MSGCHK_EN to add a checker. It compares
// the received stream against the 13-byte loopback message "Hello UART!\n\r"
// and adds the msg_ok and msg_err_cnt ports.
//
// Parameters:
//   OVERSAMPLE   sample_tick pulses per bit period (even, 8..16)
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sample_tick  one-clk pulse at OVERSAMPLE x baud
//   rx           serial line, idle high, asynchronous to clk
//   data         last good byte, held until the next good frame
//   data_valid   one-cycle strobe when data is updated
//   frame_err    one-cycle strobe when the stop bit samples low
//   busy         high whenever the FSM is not idle
//   msg_ok       (checker) one-cycle strobe per complete matching message
//   msg_err_cnt  (checker) saturating count of mismatching bytes
module uart_rx_chk #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_MSGCHK_EN
    ,
    output logic        msg_ok,
    output logic [15:0] msg_err_cnt
`endif
);

    // The sample counter is 4 bits wide, so OVERSAMPLE - 1 must fit in it.
    localparam logic [3:0] HALF = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] FULL = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t     state, state_n;
    logic [3:0] scnt, scnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] data_n;
    logic       dv_n, fe_n;
    logic       rx_m, rx_s;

    // Two-flop synchronizer. It resets to the idle line level so that reset
    // cannot produce a false start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            scnt       <= scnt_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            data       <= data_n;
            data_valid <= dv_n;
            frame_err  <= fe_n;
        end
    end

    // Next-state logic. Nothing moves except on a tick. The strobes are
    // registered, so they appear in the clk cycle after the stop-bit tick.
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        data_n  = data;
        dv_n    = 1'b0;
        fe_n    = 1'b0;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        scnt_n  = '0;
                    end
                end
                START: begin
                    // Recheck at mid start bit. If the line is high again,
                    // the low level was a glitch.
                    if (scnt == HALF) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            scnt_n  = '0;
                            bcnt_n  = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                DATA: begin
                    if (scnt == FULL) begin
                        shreg_n = {rx_s, shreg[7:1]};  // LSB arrives first
                        scnt_n  = '0;
                        bcnt_n  = bcnt + 3'd1;
                        if (bcnt == 3'd7) state_n = STOP;
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                STOP: begin
                    if (scnt == FULL) begin
                        if (rx_s) begin
                            data_n  = shreg;
                            dv_n    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            fe_n    = 1'b1;
                            state_n = BREAK;
                        end
                    end else begin
                        scnt_n = scnt + 4'd1;
                    end
                end
                BREAK: begin
                    if (rx_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef UART_RX_MSGCHK_EN
    logic [3:0] idx;

    function automatic logic [7:0] msg_byte(input logic [3:0] i);
        case (i)
            4'd0:    msg_byte = 8'h48;  // H
            4'd1:    msg_byte = 8'h65;  // e
            4'd2:    msg_byte = 8'h6C;  // l
            4'd3:    msg_byte = 8'h6C;  // l
            4'd4:    msg_byte = 8'h6F;  // o
            4'd5:    msg_byte = 8'h20;  // space
            4'd6:    msg_byte = 8'h55;  // U
            4'd7:    msg_byte = 8'h41;  // A
            4'd8:    msg_byte = 8'h52;  // R
            4'd9:    msg_byte = 8'h54;  // T
            4'd10:   msg_byte = 8'h21;  // !
            4'd11:   msg_byte = 8'h0A;
            4'd12:   msg_byte = 8'h0D;
            default: msg_byte = 8'h00;
        endcase
    endfunction

    // The checker acts on the registered strobes, so msg_ok lands in the
    // cycle after the data_valid of the final byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            msg_ok      <= 1'b0;
            msg_err_cnt <= '0;
        end else begin
            msg_ok <= 1'b0;
            if (frame_err) begin
                idx <= '0;
            end else if (data_valid) begin
                if (data == msg_byte(idx)) begin
                    if (idx == 4'd12) begin
                        idx    <= '0;
                        msg_ok <= 1'b1;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end else begin
                    if (msg_err_cnt != 16'hFFFF) msg_err_cnt <= msg_err_cnt + 16'd1;
                    // A stray 'H' may itself begin a new message.
                    idx <= (data == 8'h48) ? 4'd1 : 4'd0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_chk.sv
module tb_uart_rx_chk;
    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  data;
    logic        data_valid, frame_err, busy;
`ifdef UART_RX_MSGCHK_EN
    logic        msg_ok;
    logic [15:0] msg_err_cnt;
`endif

    uart_rx_chk #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx),
        .data(data), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
`ifdef UART_RX_MSGCHK_EN
        , .msg_ok(msg_ok), .msg_err_cnt(msg_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int tick_div = 4;
    int cyc = 0;
    int exp_q[$];     // expected strobe stream: byte value, or -1 for frame_err
    int tq[$];        // cycle stamps of data_valid
    int last_good = 0;
    int ok_seen = 0, ok_base = 0;
    // Checker reference: position, mismatches, and completed messages.
    int m_idx = 0, m_cnt = 0, m_ok = 0;
    string msg = "Hello UART!\n\r";

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Tick generator: a one-clk pulse every tick_div clocks.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            if (c >= tick_div) begin
                c = 0;
                sample_tick = 1'b1;
            end else begin
                sample_tick = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc++;

    // Monitor: every strobe must match the next expected event.
    always @(negedge clk) begin
        int e, got;
        if (!rst) begin
            if (data_valid && frame_err) chk("excl", 1, 0);
            if (data_valid || frame_err) begin
                got = data_valid ? int'(data) : -1;
                if (exp_q.size() == 0) begin
                    chk("spurious", got, 999);
                end else begin
                    e = exp_q.pop_front();
                    chk("rxbyte", got, e);
                end
                if (data_valid) tq.push_back(cyc);
            end
`ifdef UART_RX_MSGCHK_EN
            if (msg_ok) ok_seen++;
`endif
        end
    end

    // The reference model works on the byte stream alone.
    task automatic model_push(input int v);
        exp_q.push_back(v);
        if (v < 0) begin
            m_idx = 0;
        end else begin
            last_good = v;
            if (v == int'(msg[m_idx])) begin
                m_idx++;
                if (m_idx == 13) begin
                    m_idx = 0;
                    m_ok++;
                end
            end else begin
                if (m_cnt < 65535) m_cnt++;
                m_idx = (v == 'h48) ? 1 : 0;
            end
        end
    endtask

    task automatic ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (sample_tick) k++;
        end
        #1;
    endtask

    task automatic line_bit(input logic v);
        rx = v;
        ticks(OS);
    endtask

    // Send one 8N1 frame. A nonzero stop_lo holds the stop bit low for that
    // many bit periods and then idles the line for one bit.
    task automatic send(input logic [7:0] b, input int stop_lo);
        model_push(stop_lo > 0 ? -1 : int'(b));
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        if (stop_lo > 0) begin
            rx = 1'b0;
            ticks(OS * stop_lo);
            line_bit(1'b1);
        end else begin
            line_bit(1'b1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        last_good = 0;
        m_idx = 0; m_cnt = 0; m_ok = 0;
        ok_base = ok_seen;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_dv", int'(data_valid), 0);
        chk("rst_fe", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef UART_RX_MSGCHK_EN
        chk("rst_ok", int'(msg_ok), 0);
        chk("rst_cnt", int'(msg_err_cnt), 0);
`endif
        rst = 1'b0;
        ticks(4);

        // Single byte.
        send(8'hA5, 0);
        chk("a5_data", int'(data), 'hA5);
        chk("a5_busy", int'(busy), 0);

        // Glitch rejection.
        rx = 1'b0;
        ticks(5);
        rx = 1'b1;
        ticks(OS * 2);
        chk("glitch_busy", int'(busy), 0);
        chk("glitch_data", int'(data), 'hA5);

        // Framing error, then recovery.
        send(8'h3C, 3);
        chk("fe_data", int'(data), 'hA5);
        chk("fe_busy", int'(busy), 0);
        send(8'h55, 0);
        chk("after_fe", int'(data), 'h55);

        // Back-to-back frames: strobes exactly 10 bit periods apart.
        tq.delete();
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h0D, 0);
        chk("b2b_n", tq.size(), 3);
        if (tq.size() == 3) begin
            chk("b2b_gap1", tq[1] - tq[0], 10 * OS * tick_div);
            chk("b2b_gap2", tq[2] - tq[1], 10 * OS * tick_div);
        end
        chk("b2b_data", int'(data), 'h0D);

        // Reset during bit 4 of 0x81 (start, bits 0..3, then half of bit 4).
        line_bit(1'b0);
        line_bit(1'b1);
        for (int i = 0; i < 3; i++) line_bit(1'b0);
        rx = 1'b0;
        ticks(OS / 2);
        do_reset();
        chk("mid_rst_data", int'(data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        ticks(OS);
        send(8'h42, 0);
        chk("mid_rst_42", int'(data), 'h42);

`ifdef UART_RX_MSGCHK_EN
        begin
            string s2;
            s2 = "HeXlo";
            do_reset();
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < 13; i++) send(msg[i], 0);
            for (int i = 0; i < 5; i++) send(s2[i], 0);
            ticks(2);
            chk("msg_ok_n", ok_seen - ok_base, m_ok);
            chk("msg_err", int'(msg_err_cnt), m_cnt);
        end
`endif

        // Randomized frames, tick rates, framing errors, and idle gaps.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            int fe;
            tick_div = $urandom_range(1, 4);
            b  = 8'($urandom);
            fe = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            send(b, fe);
            chk("rnd_data", int'(data), last_good);
            ticks($urandom_range(0, 20));
        end

        ticks(OS);
        chk("pending", exp_q.size(), 0);
        chk("end_busy", int'(busy), 0);
`ifdef UART_RX_MSGCHK_EN
        chk("end_ok_n", ok_seen - ok_base, m_ok);
        chk("end_err", int'(msg_err_cnt), m_cnt);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
